mult_seq: RTL and testbench
===========================

// Module: mult_seq
// PURPOSE
//   Parametrised sequential shift-add multiplier; next generation of the core's 16x16 unit.
//   Adds WIDTH/signed modes, early termination on the multiplier and a busy/done/ack handshake.
//   Done is held until acknowledged or a programmable timeout expires.
//   Sits behind the SoC peripheral bus as a memory-mapped accelerator.
// PARAMETERS
//   WIDTH      16   operand width in bits (>=4); result is 2*WIDTH
//   DONE_HOLD  30   cycles done stays high without ack; 0 = hold until ack
// PORTS
//   clk          in   1         rising-edge clock
//   reset        in   1         asynchronous, active-low reset
//   init         in   1         start request, sampled only in IDLE
//   signed_mode  in   1         1 = two's-complement operands, 0 = unsigned; sampled with init
//   op_A         in   WIDTH     multiplicand, sampled in LOAD
//   op_B         in   WIDTH     multiplier, sampled in LOAD
//   ack          in   1         result consumed, honoured only in DONE
//   busy         out  1         high in LOAD, RUN and FIX
//   done         out  1         high in DONE only (registered)
//   result       out  2*WIDTH   product; changes only on FIX->DONE
// BEHAVIOUR
//   Reset (reset=0, async):
//     state=IDLE; done=0; result=0; all internal regs=0.
//   States and transitions:
//     IDLE: init=1 -> LOAD and latch signed_mode; otherwise stay.
//     LOAD: a = |op_A| zero-extended to 2*WIDTH; b = |op_B| (WIDTH bits); acc = 0.
//       neg = signed_mode & (op_A[W-1] ^ op_B[W-1]); magnitudes taken only if signed_mode.
//       Next state: |op_B|==0 -> FIX, else RUN.
//     RUN (one bit/cycle): if b[0], acc += a; a <<= 1; b >>= 1.
//       Shifted b==0 -> FIX, else stay in RUN.
//     FIX: result <= neg ? -acc : acc (2*WIDTH, wraps mod 2^(2W)); -> DONE.
//     DONE: done=1.
//       ack=1 -> IDLE.
//       DONE_HOLD>0 and DONE_HOLD cycles elapsed in DONE -> IDLE (hold counter cleared on entry).
//   Latency init-high to done-high:
//     3 + msb_index(|B|)+1 cycles; |B|==0 gives 3 cycles.
//     Worst case WIDTH+3.
//   Width rules:
//     Magnitude of -2^(W-1) is 2^(W-1) and fits unsigned WIDTH bits.
//     (-2^(W-1))^2 = 2^(2W-2) fits in 2*WIDTH signed; no overflow possible.
//   Boundary conditions:
//     init outside IDLE is ignored; ack outside DONE is ignored.
//     ack and timeout in the same cycle -> IDLE (single exit).
//     init high in the cycle DONE->IDLE is not lost: sampled next cycle in IDLE.
//     Operands/mode changing after LOAD has no effect on the running product.
//     Reset mid-operation aborts immediately; result and done forced to 0.
//     Counter width: $clog2(DONE_HOLD+1); unused when DONE_HOLD=0.
// TESTING
//   1) W=16 unsigned, A=3, B=5, init 1 cycle
//        -> result=0x0000000F; done high 6 cycles after init; busy high in between.
//   2) signed A=0xFFFD(-3), B=5 -> result=0xFFFFFFF1.
//      Signed A=0x8000, B=0x8000 -> result=0x40000000.
//   3) unsigned A=0xFFFF, B=0xFFFF
//        -> result=0xFFFE0001; done at 19 cycles (worst case).
//   4) B=0, A=0x1234 -> result=0, done 3 cycles after init.
//      init pulsed again while busy -> ignored.
//   5) DONE_HOLD=30, no ack -> done high exactly 30 cycles then IDLE, result retained.
//      DONE_HOLD=0 -> done held 100+ cycles until ack, IDLE next cycle.
//   6) reset low mid-RUN (A=7, B=0x00FF)
//        -> done=0, result=0 asynchronously.
//      After release, A=7, B=9 -> result=63.

Source files
------------

// File: rtl/mult_seq.sv
// mult_seq: sequential shift-add multiplier with signed/unsigned modes,
// early termination once the remaining multiplier bits are zero, and a
// busy/done/ack handshake. Done is held until ack, or until DONE_HOLD
// cycles have elapsed when DONE_HOLD > 0.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   init         start request, sampled only in IDLE
//   signed_mode  1 = two's-complement operands, latched together with init
//   op_A, op_B   multiplicand / multiplier, sampled in LOAD
//   ack          result consumed, honoured only in DONE
//   busy         high in LOAD, RUN and FIX (registered)
//   done         high in DONE only (registered)
//   result       2*WIDTH product, updated only on FIX->DONE
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for init
// LOAD  | capture operand magnitudes and product sign
// RUN   | one multiplier bit per cycle, exits when no bits remain
// FIX   | apply sign to the magnitude product and register it
// DONE  | result valid; leave on ack or hold-timer expiry
module mult_seq #(
  parameter int WIDTH     = 16,
  parameter int DONE_HOLD = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   op_A,
  input  logic [WIDTH-1:0]   op_B,
  input  logic               ack,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int RW    = 2 * WIDTH;
  localparam int CNT_W = (DONE_HOLD > 0) ? $clog2(DONE_HOLD + 1) : 1;
  // Hold timer is a down-counter: loaded with DONE_HOLD-1 on entry to DONE,
  // so terminal count zero falls on the DONE_HOLD-th cycle of done.
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (DONE_HOLD > 0) ? CNT_W'(DONE_HOLD - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic             neg_q, neg_d;
  logic [RW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] b_shr;

  // Magnitude of the most negative value wraps to 2^(W-1), which is exactly
  // its unsigned magnitude, so no extra bit is needed.
  always_comb begin
    mag_a = (mode_q && op_A[WIDTH-1]) ? (WIDTH'(0) - op_A) : op_A;
    mag_b = (mode_q && op_B[WIDTH-1]) ? (WIDTH'(0) - op_B) : op_B;
    b_shr = b_q >> 1;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    neg_d    = neg_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    hold_d   = hold_q;

    case (state_q)
      S_IDLE: begin
        if (init) begin
          mode_d  = signed_mode;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        a_d     = {{WIDTH{1'b0}}, mag_a};
        b_d     = mag_b;
        acc_d   = '0;
        neg_d   = mode_q & (op_A[WIDTH-1] ^ op_B[WIDTH-1]);
        state_d = (mag_b == '0) ? S_FIX : S_RUN;
      end
      S_RUN: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d = a_q << 1;
        b_d = b_shr;
        if (b_shr == '0) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = neg_q ? (RW'(0) - acc_q) : acc_q;
        hold_d   = HOLD_LOAD;
        state_d  = S_DONE;
      end
      S_DONE: begin
        // ack and timeout together still produce a single exit to IDLE
        if (ack) begin
          state_d = S_IDLE;
        end else if ((DONE_HOLD > 0) && (hold_q == '0)) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_FIX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      hold_q   <= hold_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

  localparam int W  = 16;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic          signed_mode;
  logic [W-1:0]  op_A;
  logic [W-1:0]  op_B;
  logic          ack;
  logic          busy, done;
  logic [RW-1:0] result;
  logic          busy0, done0;
  logic [RW-1:0] result0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(W), .DONE_HOLD(30)) dut (
    .clk(clk), .reset(reset), .init(init), .signed_mode(signed_mode),
    .op_A(op_A), .op_B(op_B), .ack(ack),
    .busy(busy), .done(done), .result(result)
  );

  mult_seq #(.WIDTH(W), .DONE_HOLD(0)) dut0 (
    .clk(clk), .reset(reset), .init(init), .signed_mode(signed_mode),
    .op_A(op_A), .op_B(op_B), .ack(ack),
    .busy(busy0), .done(done0), .result(result0)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands' numeric values.
  function automatic logic [RW-1:0] model_product(input bit sm, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[W-1]) sa = sa - (longint'(1) << W);
    if (sm && b[W-1]) sb = sb - (longint'(1) << W);
    p = sa * sb;
    return RW'(p);
  endfunction

  // Reference latency: 3 cycles plus one per significant bit of |B|.
  function automatic int model_latency(input bit sm, input logic [W-1:0] b);
    longint mag;
    int bits;
    mag = longint'(b);
    if (sm && b[W-1]) mag = (longint'(1) << W) - mag;
    bits = 0;
    while (mag != 0) begin
      bits++;
      mag = mag >> 1;
    end
    return 3 + bits;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, output logic [RW-1:0] exp_out);
    int n, lat;
    bit busy_ok;
    logic [RW-1:0] exp;
    exp = model_product(sm, a, b);
    lat = model_latency(sm, b);
    signed_mode = sm;
    op_A = a;
    op_B = b;
    init = 1'b1;
    step();
    init = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 2 * W + 10) begin
      if (!busy) busy_ok = 1'b0;
      if (n == 2) begin
        // operands and mode are scrambled after LOAD, plus a stray init
        op_A = W'($urandom);
        op_B = W'($urandom);
        signed_mode = 1'($urandom);
        init = 1'b1;
      end
      step();
      init = 1'b0;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " busy"}, 64'(busy_ok), 64'd1);
    check({tag, " result"}, 64'(result), 64'(exp));
    check({tag, " result0"}, 64'(result0), 64'(exp));
    check({tag, " busy_in_done"}, 64'(busy), 64'd0);
    check({tag, " done0"}, 64'(done0), 64'd1);
    exp_out = exp;
  endtask

  task automatic ack_op(input string tag, input logic [RW-1:0] exp);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check({tag, " done_after_ack"}, 64'(done), 64'd0);
    check({tag, " done0_after_ack"}, 64'(done0), 64'd0);
    check({tag, " retained"}, 64'(result), 64'(exp));
    step();
    check({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [RW-1:0] e;
    int hi;
    bit sm;
    logic [W-1:0] ra, rb;

    reset = 1'b0;
    init = 1'b0;
    signed_mode = 1'b0;
    op_A = '0;
    op_B = '0;
    ack = 1'b0;
    step();
    step();
    check("reset done", 64'(done), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset result", 64'(result), 64'd0);
    reset = 1'b1;
    step();

    run_op(1'b0, 16'd3, 16'd5, "t1", e);
    check("t1 const", 64'(result), 64'h0000000F);
    ack_op("t1", e);

    run_op(1'b1, 16'hFFFD, 16'd5, "t2a", e);
    check("t2a const", 64'(result), 64'hFFFFFFF1);
    ack_op("t2a", e);
    run_op(1'b1, 16'h8000, 16'h8000, "t2b", e);
    check("t2b const", 64'(result), 64'h40000000);
    ack_op("t2b", e);

    run_op(1'b0, 16'hFFFF, 16'hFFFF, "t3", e);
    check("t3 const", 64'(result), 64'hFFFE0001);
    ack_op("t3", e);

    run_op(1'b0, 16'h1234, 16'h0000, "t4", e);
    check("t4 const", 64'(result), 64'd0);
    // ack with init held high: DONE exits once, init starts the next op
    ack = 1'b1;
    init = 1'b1;
    step();
    ack = 1'b0;
    check("t4 single_exit done", 64'(done), 64'd0);
    check("t4 single_exit busy", 64'(busy), 64'd0);
    run_op(1'b0, 16'd11, 16'd13, "t4b", e);
    ack_op("t4b", e);

    // hold timeout on dut, indefinite hold on dut0
    run_op(1'b0, 16'd100, 16'd200, "t5", e);
    hi = 1;
    while (hi < 200) begin
      step();
      if (done) hi++;
      else break;
    end
    check("t5 done_cycles", 64'(hi), 64'd30);
    check("t5 retained", 64'(result), 64'(e));
    for (int i = 0; i < 100; i++) step();
    check("t5 dut0 still done", 64'(done0), 64'd1);
    check("t5 dut idle", 64'(done), 64'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("t5 dut0 released", 64'(done0), 64'd0);
    check("t5 dut0 retained", 64'(result0), 64'(e));

    // ack coincides with the final hold cycle
    run_op(1'b1, 16'hFF00, 16'd77, "t5b", e);
    for (int i = 0; i < 29; i++) step();
    check("t5b hold29", 64'(done), 64'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("t5b exit", 64'(done), 64'd0);
    step();
    check("t5b stays idle", 64'(busy | done), 64'd0);

    // asynchronous reset during RUN
    signed_mode = 1'b0;
    op_A = 16'd7;
    op_B = 16'h00FF;
    init = 1'b1;
    step();
    init = 1'b0;
    step();
    step();
    step();
    check("t6 running", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("t6 async done", 64'(done), 64'd0);
    check("t6 async result", 64'(result), 64'd0);
    check("t6 async busy", 64'(busy), 64'd0);
    #1;
    reset = 1'b1;
    step();
    run_op(1'b0, 16'd7, 16'd9, "t6b", e);
    check("t6b const", 64'(result), 64'd63);
    ack_op("t6b", e);

    for (int k = 0; k < 60; k++) begin
      sm = 1'($urandom);
      ra = W'($urandom);
      rb = W'($urandom >> $urandom_range(0, 32));
      if (k % 15 == 3) ra = 16'h8000;
      if (k % 15 == 7) rb = 16'h8000;
      run_op(sm, ra, rb, "rnd", e);
      ack_op("rnd", e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
